// File: rtl/clk_disp_pkg.sv
// Shared types and constants for the clock's multiplexed 7-segment display:
// segment codes, blink field select, digit slots and the scan FSM states.
package clk_disp_pkg;

  typedef enum logic [1:0] {
    ST_OFF  = 2'd0,
    ST_LOAD = 2'd1,
    ST_SCAN = 2'd2
  } disp_state_t;

  typedef enum logic [1:0] {
    FLD_SEC  = 2'd0,
    FLD_MIN  = 2'd1,
    FLD_HOUR = 2'd2,
    FLD_DAY  = 2'd3
  } field_t;

  // Digit slots in scan order, low digit of each field first
  typedef enum logic [2:0] {
    SEC0  = 3'd0,
    SEC1  = 3'd1,
    MIN0  = 3'd2,
    MIN1  = 3'd3,
    HOUR0 = 3'd4,
    HOUR1 = 3'd5,
    DAY0  = 3'd6,
    DAY1  = 3'd7
  } digit_idx_t;

  // Active-low segment codes, bit6..0 = g,f,e,d,c,b,a
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'h3F;
  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;

  // Two digits per field, so the field is the upper two bits of the slot
  function automatic field_t field_of(input logic [2:0] idx);
    return field_t'(idx[2:1]);
  endfunction

endpackage

// File: rtl/seg_scan_display_if.sv
// Digit interface between the clock core (master) and the display scanner (slave).
interface seg_scan_display_if;
  logic [3:0] DIG0, DIG1, DIG2, DIG3, DIG4, DIG5, DIG6, DIG7;
  logic       DISP_EN;
  logic       LZB_EN;
  logic       BLINK_EN;
  logic [1:0] BLINK_SEL;
  logic [7:0] AN_N;
  logic [6:0] SEG_N;
  logic       DP_N;
  logic       FRAME_SYNC;

  modport master (
    output DIG0, DIG1, DIG2, DIG3, DIG4, DIG5, DIG6, DIG7,
    output DISP_EN, LZB_EN, BLINK_EN, BLINK_SEL,
    input  AN_N, SEG_N, DP_N, FRAME_SYNC
  );

  modport slave (
    input  DIG0, DIG1, DIG2, DIG3, DIG4, DIG5, DIG6, DIG7,
    input  DISP_EN, LZB_EN, BLINK_EN, BLINK_SEL,
    output AN_N, SEG_N, DP_N, FRAME_SYNC
  );
endinterface

// File: rtl/bcd_to_seg7.sv
// Combinational BCD to active-low 7-segment decoder; codes 10..15 show a dash.
module bcd_to_seg7
  import clk_disp_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg_n
);

  always_comb begin
    case (bcd)
      4'd0:    seg_n = SEG_0;
      4'd1:    seg_n = SEG_1;
      4'd2:    seg_n = SEG_2;
      4'd3:    seg_n = SEG_3;
      4'd4:    seg_n = SEG_4;
      4'd5:    seg_n = SEG_5;
      4'd6:    seg_n = SEG_6;
      4'd7:    seg_n = SEG_7;
      4'd8:    seg_n = SEG_8;
      4'd9:    seg_n = SEG_9;
      default: seg_n = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/seg_scan_display.sv
// Scans a frame snapshot of the eight clock digits onto a multiplexed
// common-anode display, with field blink, leading-zero blank and dp separators.
module seg_scan_display
  import clk_disp_pkg::*;
#(
  parameter int DWELL      = 2,
  parameter int BLINK_HALF = 250
) (
  input logic              CLK1K,
  input logic              RSTN,
  seg_scan_display_if.slave bus
);

  localparam int DW_W = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam int BH_W = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
  localparam logic [DW_W-1:0] DWELL_LAST = DW_W'(DWELL - 1);
  localparam logic [BH_W-1:0] BLINK_LAST = BH_W'(BLINK_HALF - 1);

  disp_state_t     state_reg, state_next;
  logic [2:0]      idx_reg, idx_next;
  logic [DW_W-1:0] dwell_reg, dwell_next;
  logic [BH_W-1:0] bcnt_reg, bcnt_next;
  logic            hidden_reg, hidden_next;
  logic [3:0]      snap_reg  [8];
  logic [3:0]      snap_next [8];
  logic [3:0]      dig_in    [8];
  logic [6:0]      seg_dec   [8];
  logic [7:0]      blank_vec;
  logic            frame_end, capture;

  logic [7:0] an_n_reg, an_n_next;
  logic [6:0] seg_n_reg, seg_n_next;
  logic       dp_n_reg, dp_n_next;
  logic       fs_reg, fs_next;

  assign dig_in[0] = bus.DIG0;
  assign dig_in[1] = bus.DIG1;
  assign dig_in[2] = bus.DIG2;
  assign dig_in[3] = bus.DIG3;
  assign dig_in[4] = bus.DIG4;
  assign dig_in[5] = bus.DIG5;
  assign dig_in[6] = bus.DIG6;
  assign dig_in[7] = bus.DIG7;

  assign frame_end = (state_reg == ST_SCAN) && (idx_reg == DAY1) && (dwell_reg == DWELL_LAST);
  assign capture   = (state_reg == ST_LOAD) || (frame_end && bus.DISP_EN);

  always_ff @(posedge CLK1K or negedge RSTN) begin
    if (!RSTN) state_reg <= ST_OFF;
    else       state_reg <= state_next;
  end

  // DISP_EN is only looked at in OFF and at frame end, so frames never truncate
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_OFF:  if (bus.DISP_EN) state_next = ST_LOAD;
      ST_LOAD: state_next = ST_SCAN;
      ST_SCAN: if (frame_end && !bus.DISP_EN) state_next = ST_OFF;
      default: state_next = ST_OFF;
    endcase
  end

  always_comb begin
    idx_next   = '0;
    dwell_next = '0;
    if (state_reg == ST_SCAN) begin
      if (dwell_reg == DWELL_LAST) begin
        idx_next   = idx_reg + 3'd1;
      end else begin
        idx_next   = idx_reg;
        dwell_next = dwell_reg + DW_W'(1);
      end
    end

    // Held at zero while disabled so the first half after enabling is visible
    bcnt_next   = '0;
    hidden_next = 1'b0;
    if (bus.BLINK_EN) begin
      if (bcnt_reg == BLINK_LAST) begin
        hidden_next = ~hidden_reg;
      end else begin
        bcnt_next   = bcnt_reg + BH_W'(1);
        hidden_next = hidden_reg;
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_digit
      logic blink_hit;
      logic lzb_hit;

      assign snap_next[gi] = capture ? dig_in[gi] : snap_reg[gi];

      bcd_to_seg7 u_dec (
        .bcd   (snap_next[gi]),
        .seg_n (seg_dec[gi])
      );

      assign blink_hit = bus.BLINK_EN && hidden_next &&
                         (field_of(3'(gi)) == field_t'(bus.BLINK_SEL));
      assign lzb_hit   = ((gi == int'(HOUR1)) || (gi == int'(DAY1))) &&
                         bus.LZB_EN && (snap_next[gi] == 4'd0);
      assign blank_vec[gi] = blink_hit || lzb_hit;
    end
  endgenerate

  // Decoded from next-state values so outputs move on the same edge as idx/dwell
  always_comb begin
    an_n_next  = 8'hFF;
    seg_n_next = SEG_BLANK;
    dp_n_next  = 1'b1;
    fs_next    = 1'b0;
    if (state_next == ST_SCAN) begin
      an_n_next = ~(8'd1 << idx_next);
      fs_next   = (idx_next == SEC0) && (dwell_next == '0);
      if (!blank_vec[idx_next]) begin
        seg_n_next = seg_dec[idx_next];
        dp_n_next  = !((idx_next == MIN0) || (idx_next == HOUR0) || (idx_next == DAY0));
      end
    end
  end

  always_ff @(posedge CLK1K or negedge RSTN) begin
    if (!RSTN) begin
      idx_reg    <= '0;
      dwell_reg  <= '0;
      bcnt_reg   <= '0;
      hidden_reg <= 1'b0;
      for (int i = 0; i < 8; i++) snap_reg[i] <= '0;
      an_n_reg   <= 8'hFF;
      seg_n_reg  <= SEG_BLANK;
      dp_n_reg   <= 1'b1;
      fs_reg     <= 1'b0;
    end else begin
      idx_reg    <= idx_next;
      dwell_reg  <= dwell_next;
      bcnt_reg   <= bcnt_next;
      hidden_reg <= hidden_next;
      snap_reg   <= snap_next;
      an_n_reg   <= an_n_next;
      seg_n_reg  <= seg_n_next;
      dp_n_reg   <= dp_n_next;
      fs_reg     <= fs_next;
    end
  end

  assign bus.AN_N       = an_n_reg;
  assign bus.SEG_N      = seg_n_reg;
  assign bus.DP_N       = dp_n_reg;
  assign bus.FRAME_SYNC = fs_reg;

endmodule

// File: tb/tb_seg_scan_display.sv
// Bench for seg_scan_display: a frame-position reference model feeds a
// scoreboard queue, and each scenario task also checks fixed expected codes.
module tb_seg_scan_display;

  localparam int DWELL      = 2;
  localparam int BLINK_HALF = 4;
  localparam int FRAME      = 8 * DWELL;

  typedef struct packed {
    logic [7:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       fs;
  } obs_t;

  typedef struct packed {
    logic [1:0]  st;   // 0 off, 1 load, 2 scan
    logic [7:0]  pos;  // cycle within frame
    logic [7:0]  bcnt;
    logic        hid;
    logic [31:0] snap; // nibble k = digit k
  } mdl_t;

  localparam obs_t OBS_RST = {8'hFF, 7'h7F, 1'b1, 1'b0};
  localparam logic [7:0] AN_TAB  [8] = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F};
  localparam logic [6:0] SEG_TAB [8] = '{7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h78, 7'h7F};
  localparam logic       DP_TAB  [8] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

  logic CLK1K = 1'b0;
  logic RSTN  = 1'b0;
  always #5 CLK1K = ~CLK1K;

  seg_scan_display_if bus ();

  seg_scan_display #(.DWELL(DWELL), .BLINK_HALF(BLINK_HALF)) dut (
    .CLK1K (CLK1K),
    .RSTN  (RSTN),
    .bus   (bus)
  );

  int   n_cmp = 0;
  int   n_bad = 0;
  obs_t sb_q[$];
  mdl_t mdl;

  function automatic logic [6:0] ref_seg(input logic [3:0] v);
    case (v)
      4'd0: return 7'h40;
      4'd1: return 7'h79;
      4'd2: return 7'h24;
      4'd3: return 7'h30;
      4'd4: return 7'h19;
      4'd5: return 7'h12;
      4'd6: return 7'h02;
      4'd7: return 7'h78;
      4'd8: return 7'h00;
      4'd9: return 7'h10;
      default: return 7'h3F;
    endcase
  endfunction

  function automatic logic [31:0] digs();
    return {bus.DIG7, bus.DIG6, bus.DIG5, bus.DIG4, bus.DIG3, bus.DIG2, bus.DIG1, bus.DIG0};
  endfunction

  function automatic mdl_t mdl_step(input mdl_t m);
    mdl_t r;
    r = m;
    case (m.st)
      2'd0: if (bus.DISP_EN) r.st = 2'd1;
      2'd1: begin
        r.st   = 2'd2;
        r.pos  = 8'd0;
        r.snap = digs();
      end
      default: begin
        if (int'(m.pos) == FRAME - 1) begin
          r.pos = 8'd0;
          if (bus.DISP_EN) r.snap = digs();
          else             r.st   = 2'd0;
        end else begin
          r.pos = m.pos + 8'd1;
        end
      end
    endcase
    if (!bus.BLINK_EN) begin
      r.bcnt = 8'd0;
      r.hid  = 1'b0;
    end else if (int'(m.bcnt) == BLINK_HALF - 1) begin
      r.bcnt = 8'd0;
      r.hid  = !m.hid;
    end else begin
      r.bcnt = m.bcnt + 8'd1;
    end
    return r;
  endfunction

  function automatic obs_t mdl_obs(input mdl_t m);
    obs_t       o;
    int         k;
    logic [3:0] v;
    bit         blank;
    if (m.st != 2'd2) return OBS_RST;
    k = int'(m.pos) / DWELL;
    v = m.snap[4*k +: 4];
    blank = (bus.BLINK_EN && m.hid && ((k / 2) == int'(bus.BLINK_SEL))) ||
            (bus.LZB_EN && (k == 5 || k == 7) && (v == 4'd0));
    o.an  = ~(8'h01 << k);
    o.seg = blank ? 7'h7F : ref_seg(v);
    o.dp  = (!blank && (k == 2 || k == 4 || k == 6)) ? 1'b0 : 1'b1;
    o.fs  = (m.pos == 8'd0);
    return o;
  endfunction

  // Reference model: predicts the registered outputs after each edge
  always @(posedge CLK1K or negedge RSTN) begin
    if (!RSTN) begin
      mdl <= '0;
      sb_q.delete();
      sb_q.push_back(OBS_RST);
    end else begin
      sb_q.push_back(mdl_obs(mdl_step(mdl)));
      mdl <= mdl_step(mdl);
    end
  end

  task automatic sample(output obs_t got, output obs_t want, output bit ok);
    @(posedge CLK1K);
    #1;
    got = {bus.AN_N, bus.SEG_N, bus.DP_N, bus.FRAME_SYNC};
    ok  = (sb_q.size() != 0);
    if (ok) want = sb_q.pop_front();
    else    want = OBS_RST;
    if (got.fs) $display("[%0t] frame start, digit0 seg=%h", $time, got.seg);
  endtask

  task automatic set_digits(input logic [31:0] d);
    bus.DIG0 = d[3:0];   bus.DIG1 = d[7:4];   bus.DIG2 = d[11:8];  bus.DIG3 = d[15:12];
    bus.DIG4 = d[19:16]; bus.DIG5 = d[23:20]; bus.DIG6 = d[27:24]; bus.DIG7 = d[31:28];
  endtask

  task automatic test_reset();
    obs_t got, want;
    bit   ok;
    RSTN = 1'b0;
    bus.DISP_EN = 1'b0; bus.LZB_EN = 1'b0; bus.BLINK_EN = 1'b0; bus.BLINK_SEL = 2'b00;
    set_digits(32'h0);
    repeat (4) begin
      sample(got, want, ok);
      n_cmp++;
      if (got !== OBS_RST) begin
        n_bad++;
        $display("FAIL reset_hold got=%h want=%h", got, OBS_RST);
      end
    end
    RSTN = 1'b1;
    for (int c = 0; c < 12; c++) begin
      sample(got, want, ok);
      n_cmp++;
      if (!ok || got !== want) begin
        n_bad++;
        $display("FAIL sb_off c=%0d got=%h want=%h", c, got, want);
      end
      n_cmp++;
      if (got !== OBS_RST) begin
        n_bad++;
        $display("FAIL off_idle c=%0d got=%h want=%h", c, got, OBS_RST);
      end
    end
  endtask

  task automatic test_scan_order();
    obs_t got, want, fixed;
    bit   ok;
    int   k;
    set_digits(32'h0712_3456);
    bus.LZB_EN  = 1'b1;
    bus.DISP_EN = 1'b1;
    sample(got, want, ok);
    n_cmp++;
    if (!ok || got !== want || got !== OBS_RST) begin
      n_bad++;
      $display("FAIL load_blank got=%h want=%h", got, OBS_RST);
    end
    for (int c = 0; c < 2 * FRAME; c++) begin
      sample(got, want, ok);
      n_cmp++;
      if (!ok || got !== want) begin
        n_bad++;
        $display("FAIL sb_scan c=%0d got=%h want=%h", c, got, want);
      end
      k = (c / DWELL) % 8;
      fixed.an  = AN_TAB[k];
      fixed.seg = SEG_TAB[k];
      fixed.dp  = DP_TAB[k];
      fixed.fs  = ((c % FRAME) == 0);
      n_cmp++;
      if (got !== fixed) begin
        n_bad++;
        $display("FAIL scan_order c=%0d got=%h want=%h", c, got, fixed);
      end
    end
  endtask

  task automatic test_tear_free();
    obs_t got, want;
    bit   ok;
    for (int c = 0; c < 2 * FRAME; c++) begin
      if (c == 7) bus.DIG0 = 4'd9;
      sample(got, want, ok);
      n_cmp++;
      if (!ok || got !== want) begin
        n_bad++;
        $display("FAIL sb_tear c=%0d got=%h want=%h", c, got, want);
      end
      if (c == 8) begin
        n_cmp++;
        if (got.an !== 8'hEF || got.seg !== 7'h24) begin
          n_bad++;
          $display("FAIL tear_mid got an=%h seg=%h want an=EF seg=24", got.an, got.seg);
        end
      end
      if (c == FRAME) begin
        n_cmp++;
        if (got.an !== 8'hFE || got.seg !== 7'h10 || got.fs !== 1'b1) begin
          n_bad++;
          $display("FAIL tear_next got an=%h seg=%h fs=%b want an=FE seg=10 fs=1", got.an, got.seg, got.fs);
        end
      end
    end
  endtask

  task automatic test_invalid_lzb();
    obs_t got, want;
    bit   ok;
    bus.DIG3   = 4'hC;
    bus.DIG5   = 4'h0;
    bus.LZB_EN = 1'b1;
    for (int c = 0; c < 2 * FRAME; c++) begin
      if (c == FRAME) bus.LZB_EN = 1'b0;
      sample(got, want, ok);
      n_cmp++;
      if (!ok || got !== want) begin
        n_bad++;
        $display("FAIL sb_lzb c=%0d got=%h want=%h", c, got, want);
      end
      if (c == 6 && got.seg !== 7'h3F) begin
        n_bad++;
        $display("FAIL invalid_dash got=%h want=3F", got.seg);
      end
      if (c == 10 && (got.seg !== 7'h7F || got.dp !== 1'b1)) begin
        n_bad++;
        $display("FAIL lzb_hour got seg=%h dp=%b want seg=7F dp=1", got.seg, got.dp);
      end
      if (c == 14 && got.seg !== 7'h7F) begin
        n_bad++;
        $display("FAIL lzb_day got=%h want=7F", got.seg);
      end
      if ((c == 26 || c == 30) && got.seg !== 7'h40) begin
        n_bad++;
        $display("FAIL lzb_off c=%0d got=%h want=40", c, got.seg);
      end
      if (c == 6 || c == 10 || c == 14 || c == 26 || c == 30) n_cmp++;
    end
  endtask

  task automatic test_blink();
    obs_t got, want;
    bit   ok;
    bit   hide;
    bus.BLINK_SEL = 2'b01;
    bus.BLINK_EN  = 1'b1;
    for (int j = 1; j <= 2 * FRAME; j++) begin
      if (j == 22) bus.BLINK_EN = 1'b0;
      sample(got, want, ok);
      n_cmp++;
      if (!ok || got !== want) begin
        n_bad++;
        $display("FAIL sb_blink j=%0d got=%h want=%h", j, got, want);
      end
      if (j < 22 && (got.an === 8'hFB || got.an === 8'hF7)) begin
        hide = ((j / BLINK_HALF) % 2) == 1;
        n_cmp++;
        if ((got.seg === 7'h7F) !== hide) begin
          n_bad++;
          $display("FAIL blink_phase j=%0d got seg=%h want hidden=%0d", j, got.seg, hide);
        end
      end
      if (j == 22) begin
        n_cmp++;
        if (got.an !== 8'hFB || got.seg !== 7'h19 || got.dp !== 1'b0) begin
          n_bad++;
          $display("FAIL blink_release got an=%h seg=%h dp=%b want FB/19/0", got.an, got.seg, got.dp);
        end
      end
    end
  endtask

  task automatic test_shutdown();
    obs_t got, want, live;
    bit   ok;
    for (int c = 0; c < FRAME + 8; c++) begin
      if (c == 7) bus.DISP_EN = 1'b0;
      sample(got, want, ok);
      n_cmp++;
      if (!ok || got !== want) begin
        n_bad++;
        $display("FAIL sb_shutdown c=%0d got=%h want=%h", c, got, want);
      end
      n_cmp++;
      if (c < FRAME && got.an !== AN_TAB[c / DWELL]) begin
        n_bad++;
        $display("FAIL shutdown_scan c=%0d got an=%h want %h", c, got.an, AN_TAB[c / DWELL]);
      end else if (c >= FRAME && got !== OBS_RST) begin
        n_bad++;
        $display("FAIL shutdown_off c=%0d got=%h want=%h", c, got, OBS_RST);
      end
    end
    bus.DISP_EN = 1'b1;
    for (int c = 0; c < 6; c++) begin
      sample(got, want, ok);
      n_cmp++;
      if (!ok || got !== want) begin
        n_bad++;
        $display("FAIL sb_restart c=%0d got=%h want=%h", c, got, want);
      end
    end
    #3;
    RSTN = 1'b0;
    #1;
    live = {bus.AN_N, bus.SEG_N, bus.DP_N, bus.FRAME_SYNC};
    n_cmp++;
    if (live !== OBS_RST) begin
      n_bad++;
      $display("FAIL async_reset got=%h want=%h", live, OBS_RST);
    end
    bus.DISP_EN = 1'b0;
    repeat (2) begin
      sample(got, want, ok);
      n_cmp++;
      if (got !== OBS_RST) begin
        n_bad++;
        $display("FAIL reset_hold2 got=%h want=%h", got, OBS_RST);
      end
    end
    RSTN = 1'b1;
    for (int c = 0; c < 4; c++) begin
      sample(got, want, ok);
      n_cmp++;
      if (!ok || got !== want) begin
        n_bad++;
        $display("FAIL sb_post_reset c=%0d got=%h want=%h", c, got, want);
      end
    end
  endtask

  initial begin
    test_reset();
    test_scan_order();
    test_tear_free();
    test_invalid_lzb();
    test_blink();
    test_shutdown();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired after %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
